reg_file: RTL and testbench

Parametrised multi-entry register file for the soft CPU, the successor of the single 8-bit enable register. It provides one write port, two registered read ports with write-to-read bypass, an optional hardwired-zero entry 0, and a per-entry busy scoreboard that the issue logic uses to detect pending writebacks. It sits between decode/issue (read and busy-set side) and writeback (write side).

---
 rtl/reg_file_pkg.sv | 20 ++
 rtl/reg_file_scoreboard.sv | 76 +++++++
 rtl/reg_file.sv | 95 +++++++++
 tb/tb_reg_file.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module   : reg_file_pkg
// Purpose  : Shared constants and address-width helper for the CPU register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

  localparam int C_DEFAULT_WIDTH = 8;
  localparam int C_DEFAULT_DEPTH = 8;

  // ceil(log2(depth)) but never narrower than one bit
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
// ============================================================================
// Module   : reg_file_scoreboard
// Purpose  : Per-entry pending-writeback bits with two registered lookup ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH    = C_DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          busy_set,
  input  logic [AW-1:0] busy_addr,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          busy_a,
  output logic          busy_b
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             busy_a_q, busy_a_d;
  logic             busy_b_q, busy_b_d;

  always_comb begin
    busy_d   = busy_q;
    busy_a_d = busy_a_q;
    busy_b_d = busy_b_q;
    if (enable) begin
      // clear first so a same-cycle set on the same entry wins
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_addr == AW'(i)))
          busy_d[i] = 1'b0;
        if (busy_set && (busy_addr == AW'(i)))
          busy_d[i] = 1'b1;
      end
    end
    if (ZERO_REG != 0)
      busy_d[0] = 1'b0;
    if (enable) begin
      busy_a_d = 1'b0;
      busy_b_d = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_addr_a == AW'(i))
          busy_a_d = busy_d[i];
        if (rd_addr_b == AW'(i))
          busy_b_d = busy_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q   <= '0;
      busy_a_q <= 1'b0;
      busy_b_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      busy_a_q <= busy_a_d;
      busy_b_q <= busy_b_d;
    end
  end

  assign busy_a = busy_a_q;
  assign busy_b = busy_b_q;

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module   : reg_file
// Purpose  : Multi-entry register file, one write port, two bypassed read ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = C_DEFAULT_WIDTH,
  parameter int DEPTH    = C_DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             busy_set,
  input  logic [AW-1:0]    busy_addr,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             busy_a,
  output logic             busy_b
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [WIDTH-1:0]            rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0]            rd_data_b_q, rd_data_b_d;

  always_comb begin
    mem_d       = mem_q;
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (enable) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_addr == AW'(i)))
          mem_d[i] = wr_data;
      end
    end
    if (ZERO_REG != 0)
      mem_d[0] = '0;
    // reading the post-write array gives the write-to-read bypass for free
    if (enable) begin
      rd_data_a_d = '0;
      rd_data_b_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_addr_a == AW'(i))
          rd_data_a_d = mem_d[i];
        if (rd_addr_b == AW'(i))
          rd_data_b_d = mem_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q       <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      mem_q       <= mem_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;

  reg_file_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module   : tb_reg_file
// Purpose  : Self-checking bench for reg_file (default and DEPTH=6/WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        we, bs;
  logic [2:0]  wa, ba, ra, rb;
  logic [7:0]  wd;
  logic [7:0]  rda, rdb;
  logic        bya, byb;

  logic        we6, bs6;
  logic [2:0]  wa6, ba6, ra6, rb6;
  logic [15:0] wd6;
  logic [15:0] rda6, rdb6;
  logic        bya6, byb6;

  // reference state: plain arrays updated from the behavioural rules
  logic [7:0]  mem8 [8];
  logic        busy8 [8];
  logic [7:0]  e_rda, e_rdb;
  logic        e_bya, e_byb;
  logic [15:0] mem6 [6];
  logic        busy6 [6];
  logic [15:0] e_rda6, e_rdb6;
  logic        e_bya6, e_byb6;

  int n_cmp;
  int n_err;

  reg_file dut (
    .clk(clk), .reset(rst_n), .enable(en),
    .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .busy_set(bs), .busy_addr(ba),
    .rd_addr_a(ra), .rd_addr_b(rb),
    .rd_data_a(rda), .rd_data_b(rdb),
    .busy_a(bya), .busy_b(byb)
  );

  reg_file #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1)) dut6 (
    .clk(clk), .reset(rst_n), .enable(en),
    .wr_en(we6), .wr_addr(wa6), .wr_data(wd6),
    .busy_set(bs6), .busy_addr(ba6),
    .rd_addr_a(ra6), .rd_addr_b(rb6),
    .rd_data_a(rda6), .rd_data_b(rdb6),
    .busy_a(bya6), .busy_b(byb6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin mem8[i] = '0; busy8[i] = 1'b0; end
    for (int i = 0; i < 6; i++) begin mem6[i] = '0; busy6[i] = 1'b0; end
    e_rda = '0; e_rdb = '0; e_bya = 1'b0; e_byb = 1'b0;
    e_rda6 = '0; e_rdb6 = '0; e_bya6 = 1'b0; e_byb6 = 1'b0;
  endtask

  task automatic idle();
    we = 0; bs = 0; wa = 0; ba = 0; wd = 0; ra = 0; rb = 0;
    we6 = 0; bs6 = 0; wa6 = 0; ba6 = 0; wd6 = 0; ra6 = 0; rb6 = 0;
  endtask

  // one clock edge: apply the architectural rules to the model, then settle
  task automatic step();
    @(posedge clk);
    if (en) begin
      if (we && wa != 0) mem8[wa] = wd;
      if (we) busy8[wa] = 1'b0;
      if (bs && ba != 0) busy8[ba] = 1'b1;
      e_rda = mem8[ra]; e_rdb = mem8[rb];
      e_bya = busy8[ra]; e_byb = busy8[rb];
      if (we6 && wa6 < 6 && wa6 != 0) mem6[wa6] = wd6;
      if (we6 && wa6 < 6) busy6[wa6] = 1'b0;
      if (bs6 && ba6 < 6 && ba6 != 0) busy6[ba6] = 1'b1;
      e_rda6 = (ra6 < 6) ? mem6[ra6] : 16'h0;
      e_rdb6 = (rb6 < 6) ? mem6[rb6] : 16'h0;
      e_bya6 = (ra6 < 6) ? busy6[ra6] : 1'b0;
      e_byb6 = (rb6 < 6) ? busy6[rb6] : 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b1; idle();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (rda !== 8'h00) begin n_err++; $display("FAIL por_rda: got %h expected 00", rda); end
    n_cmp++; if (bya !== 1'b0) begin n_err++; $display("FAIL por_bya: got %b expected 0", bya); end
    n_cmp++; if (rda6 !== 16'h0) begin n_err++; $display("FAIL por_rda6: got %h expected 0000", rda6); end
    #8 rst_n = 1'b1;
    for (int i = 1; i < 8; i++) begin
      we = 1; wa = 3'(i); wd = 8'(i * 8'h11);
      step();
    end
    we = 0; bs = 1; ba = 4; ra = 4; rb = 7;
    step();
    n_cmp++; if (rda !== 8'h44) begin n_err++; $display("FAIL fill_rda: got %h expected 44", rda); end
    n_cmp++; if (bya !== 1'b1) begin n_err++; $display("FAIL fill_bya: got %b expected 1", bya); end
    n_cmp++; if (rdb !== 8'h77) begin n_err++; $display("FAIL fill_rdb: got %h expected 77", rdb); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (rda !== 8'h00 || rdb !== 8'h00) begin n_err++; $display("FAIL async_rd: got %h/%h expected 00/00", rda, rdb); end
    n_cmp++; if (bya !== 1'b0 || byb !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b/%b expected 0/0", bya, byb); end
    idle();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(7 - i);
      step();
      n_cmp++; if (rda !== 8'h00 || rdb !== 8'h00) begin n_err++; $display("FAIL post_rst_rd[%0d]: got %h/%h expected 00/00", i, rda, rdb); end
      n_cmp++; if (bya !== 1'b0 || byb !== 1'b0) begin n_err++; $display("FAIL post_rst_busy[%0d]: got %b/%b expected 0/0", i, bya, byb); end
    end
  endtask

  task automatic test_write_read();
    idle();
    we = 1; wa = 3; wd = 8'hA5;
    step();
    we = 0; ra = 3;
    step();
    n_cmp++; if (rda !== 8'hA5) begin n_err++; $display("FAIL wr_rd_a: got %h expected a5", rda); end
    we = 1; wa = 5; wd = 8'h3C; rb = 5;
    step();
    n_cmp++; if (rdb !== 8'h3C) begin n_err++; $display("FAIL bypass_b: got %h expected 3c", rdb); end
    n_cmp++; if (rda !== 8'hA5) begin n_err++; $display("FAIL hold_a: got %h expected a5", rda); end
  endtask

  task automatic test_scoreboard();
    idle();
    bs = 1; ba = 2; ra = 2;
    step();
    n_cmp++; if (bya !== 1'b1) begin n_err++; $display("FAIL sb_set: got %b expected 1", bya); end
    bs = 0; we = 1; wa = 2; wd = 8'h11;
    step();
    n_cmp++; if (bya !== 1'b0) begin n_err++; $display("FAIL sb_clear: got %b expected 0", bya); end
    n_cmp++; if (rda !== 8'h11) begin n_err++; $display("FAIL sb_clear_data: got %h expected 11", rda); end
    bs = 1; ba = 2; we = 1; wa = 2; wd = 8'h22;
    step();
    n_cmp++; if (bya !== 1'b1) begin n_err++; $display("FAIL sb_set_wins: got %b expected 1", bya); end
    n_cmp++; if (rda !== 8'h22) begin n_err++; $display("FAIL sb_set_wins_data: got %h expected 22", rda); end
  endtask

  task automatic test_zero_reg();
    idle();
    we = 1; wa = 0; wd = 8'hFF; bs = 1; ba = 0; ra = 0; rb = 0;
    step();
    n_cmp++; if (rda !== 8'h00 || rdb !== 8'h00) begin n_err++; $display("FAIL zero_bypass: got %h/%h expected 00/00", rda, rdb); end
    n_cmp++; if (bya !== 1'b0 || byb !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b/%b expected 0/0", bya, byb); end
    idle();
    step();
    n_cmp++; if (rda !== 8'h00 || bya !== 1'b0) begin n_err++; $display("FAIL zero_after: got %h/%b expected 00/0", rda, bya); end
  endtask

  task automatic test_enable();
    idle();
    ra = 3; rb = 5;
    step();
    n_cmp++; if (rda !== 8'hA5 || rdb !== 8'h3C) begin n_err++; $display("FAIL en_pre: got %h/%h expected a5/3c", rda, rdb); end
    en = 0;
    for (int k = 0; k < 3; k++) begin
      we = 1; wa = 3; wd = 8'($urandom); bs = 1; ba = 5;
      ra = 3'($urandom); rb = 3'($urandom);
      step();
      n_cmp++; if (rda !== 8'hA5 || rdb !== 8'h3C) begin n_err++; $display("FAIL en_low_rd[%0d]: got %h/%h expected a5/3c", k, rda, rdb); end
      n_cmp++; if (bya !== 1'b0 || byb !== 1'b0) begin n_err++; $display("FAIL en_low_busy[%0d]: got %b/%b expected 0/0", k, bya, byb); end
    end
    en = 1; idle(); ra = 3; rb = 5;
    step();
    n_cmp++; if (rda !== 8'hA5 || rdb !== 8'h3C) begin n_err++; $display("FAIL en_resume_rd: got %h/%h expected a5/3c", rda, rdb); end
    n_cmp++; if (bya !== 1'b0 || byb !== 1'b0) begin n_err++; $display("FAIL en_resume_busy: got %b/%b expected 0/0", bya, byb); end
  endtask

  task automatic test_depth6();
    idle();
    we6 = 1; wa6 = 7; wd6 = 16'h1234; bs6 = 1; ba6 = 7; ra6 = 7; rb6 = 6;
    step();
    n_cmp++; if (rda6 !== 16'h0 || bya6 !== 1'b0) begin n_err++; $display("FAIL d6_invalid_a: got %h/%b expected 0000/0", rda6, bya6); end
    n_cmp++; if (rdb6 !== 16'h0 || byb6 !== 1'b0) begin n_err++; $display("FAIL d6_invalid_b: got %h/%b expected 0000/0", rdb6, byb6); end
    bs6 = 0; wa6 = 5; wd6 = 16'hBEEF; ra6 = 5;
    step();
    n_cmp++; if (rda6 !== 16'hBEEF) begin n_err++; $display("FAIL d6_bypass: got %h expected beef", rda6); end
    we6 = 0; ra6 = 7; rb6 = 5;
    step();
    n_cmp++; if (rdb6 !== 16'hBEEF) begin n_err++; $display("FAIL d6_readback: got %h expected beef", rdb6); end
    n_cmp++; if (rda6 !== 16'h0) begin n_err++; $display("FAIL d6_entry7: got %h expected 0000", rda6); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      en  = ($urandom_range(0, 9) != 0);
      we  = 1'($urandom); wa = 3'($urandom); wd = 8'($urandom);
      bs  = ($urandom_range(0, 3) == 0); ba = 3'($urandom);
      ra  = 3'($urandom); rb = 3'($urandom);
      we6 = 1'($urandom); wa6 = 3'($urandom); wd6 = 16'($urandom);
      bs6 = ($urandom_range(0, 3) == 0); ba6 = 3'($urandom);
      ra6 = 3'($urandom); rb6 = 3'($urandom);
      step();
      n_cmp++; if (rda !== e_rda || rdb !== e_rdb) begin n_err++; $display("FAIL rand_rd[%0d]: got %h/%h expected %h/%h", k, rda, rdb, e_rda, e_rdb); end
      n_cmp++; if (bya !== e_bya || byb !== e_byb) begin n_err++; $display("FAIL rand_busy[%0d]: got %b/%b expected %b/%b", k, bya, byb, e_bya, e_byb); end
      n_cmp++; if (rda6 !== e_rda6 || rdb6 !== e_rdb6) begin n_err++; $display("FAIL rand_rd6[%0d]: got %h/%h expected %h/%h", k, rda6, rdb6, e_rda6, e_rdb6); end
      n_cmp++; if (bya6 !== e_bya6 || byb6 !== e_byb6) begin n_err++; $display("FAIL rand_busy6[%0d]: got %b/%b expected %b/%b", k, bya6, byb6, e_bya6, e_byb6); end
    end
    en = 1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    test_reset();
    test_write_read();
    test_scoreboard();
    test_zero_reg();
    test_enable();
    test_depth6();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
